// File: rtl/detector_sequencia.sv
// ---------------------------------------------------------------------------
// detector_sequencia: overlapping 1011 Moore detector with a saturating hit
// counter and an MSB-first serial-to-parallel word builder.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module detector_sequencia #(
  parameter int CONT_W    = 8,
  parameter int PALAVRA_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entrada,
  input  logic                 habilita,
  input  logic                 limpa_cont,
  output logic                 detectado,
  output logic [CONT_W-1:0]    contagem,
  output logic [2:0]           estado,
  output logic [PALAVRA_W-1:0] palavra,
  output logic                 palavra_valida
);

  localparam int              IDX_W   = (PALAVRA_W > 1) ? $clog2(PALAVRA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PALAVRA_W - 1);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    S1     = 3'd1,
    S10    = 3'd2,
    S101   = 3'd3,
    S1011  = 3'd4
  } estado_t;

  estado_t                state_q, state_d;
  logic                   detectado_q, detectado_d;
  logic [CONT_W-1:0]      contagem_q, contagem_d;
  logic [PALAVRA_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PALAVRA_W-1:0]   palavra_q, palavra_d;
  logic                   valida_q, valida_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= OCIOSO;
      detectado_q <= 1'b0;
      contagem_q  <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      palavra_q   <= '0;
      valida_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      detectado_q <= detectado_d;
      contagem_q  <= contagem_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      palavra_q   <= palavra_d;
      valida_q    <= valida_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO: if (habilita) state_d = entrada ? S1    : OCIOSO;
      S1:     if (habilita) state_d = entrada ? S1    : S10;
      S10:    if (habilita) state_d = entrada ? S101  : OCIOSO;
      S101:   if (habilita) state_d = entrada ? S1011 : S10;
      S1011:  if (habilita) state_d = entrada ? S1    : S10;
      // Unused codes fall back to idle even while sampling is paused.
      default: state_d = OCIOSO;
    endcase

    // S1011 can only be entered, never held, so this marks a fresh hit.
    detectado_d = habilita && (state_d == S1011);

    contagem_d = contagem_q;
    if (limpa_cont) begin
      contagem_d = '0;
    end else if (detectado_d && (contagem_q != {CONT_W{1'b1}})) begin
      contagem_d = contagem_q + CONT_W'(1);
    end

    shift_d   = shift_q;
    idx_d     = idx_q;
    palavra_d = palavra_q;
    valida_d  = 1'b0;
    if (habilita) begin
      shift_d = {shift_q[PALAVRA_W-2:0], entrada};
      if (idx_q == IDX_MAX) begin
        idx_d     = '0;
        palavra_d = shift_d;
        valida_d  = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  assign detectado      = detectado_q;
  assign contagem       = contagem_q;
  assign estado         = state_q;
  assign palavra        = palavra_q;
  assign palavra_valida = valida_q;

endmodule

`default_nettype wire

// File: tb/tb_detector_sequencia.sv
// Testbench for detector_sequencia: vector table, directed corner sequences
// and randomized traffic against a bit-history reference model.
`default_nettype none

module tb_detector_sequencia;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entrada = 1'b0;
  logic       habilita = 1'b1;
  logic       limpa_cont = 1'b0;
  logic       detectado;
  logic [7:0] contagem;
  logic [2:0] estado;
  logic [7:0] palavra;
  logic       palavra_valida;

  int checks = 0;
  int errors = 0;

  // Reference model state: every enabled bit since the last reset.
  int         hist[$];
  int         m_state = 0;
  int         m_det = 0;
  int         m_cnt = 0;
  int         m_pal = 0;
  int         m_val = 0;
  int         pat[4] = '{1, 0, 1, 1};

  detector_sequencia #(.CONT_W(8), .PALAVRA_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .entrada       (entrada),
    .habilita      (habilita),
    .limpa_cont    (limpa_cont),
    .detectado     (detectado),
    .contagem      (contagem),
    .estado        (estado),
    .palavra       (palavra),
    .palavra_valida(palavra_valida)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Longest tail of the history that is also a prefix of 1011.
  function automatic int match_len();
    int n = hist.size();
    for (int k = 4; k >= 1; k--) begin
      if (n >= k) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (hist[n - k + j] != pat[j]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic int last_word();
    int w = 0;
    int n = hist.size();
    for (int j = 0; j < 8; j++) w = ((w << 1) | hist[n - 8 + j]) & 8'hFF;
    return w;
  endfunction

  task automatic model_edge(input bit rst_n, input bit hab, input bit ent, input bit clr);
    if (!rst_n) begin
      hist.delete();
      m_state = 0; m_det = 0; m_cnt = 0; m_pal = 0; m_val = 0;
    end else begin
      m_det = 0;
      m_val = 0;
      if (hab) begin
        hist.push_back(int'(ent));
        m_state = match_len();
        m_det   = (m_state == 4) ? 1 : 0;
        if (hist.size() % 8 == 0) begin
          m_pal = last_word();
          m_val = 1;
        end
      end
      if (clr) m_cnt = 0;
      else if (m_det == 1 && m_cnt < 255) m_cnt++;
    end
  endtask

  // One clock: drive, clock, then sample 1 ns after the edge against the model.
  task automatic step(input bit rst_n, input bit hab, input bit ent, input bit clr);
    reset = rst_n; habilita = hab; entrada = ent; limpa_cont = clr;
    @(posedge clk);
    #1;
    model_edge(rst_n, hab, ent, clr);
    chk("estado",         int'(estado),         m_state);
    chk("detectado",      int'(detectado),      m_det);
    chk("contagem",       int'(contagem),       m_cnt);
    chk("palavra",        int'(palavra),        m_pal);
    chk("palavra_valida", int'(palavra_valida), m_val);
  endtask

  typedef struct {
    bit rst_n; bit hab; bit ent; bit clr;
    int st; int det; int cnt; int pal; int val;
  } vec_t;

  vec_t tbl[22];

  initial begin
    // rst_n hab ent clr | estado det cnt palavra valida
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[2]  = '{1, 1, 1, 0, 1, 0, 0, 8'h00, 0};
    tbl[3]  = '{1, 1, 0, 0, 2, 0, 0, 8'h00, 0};
    tbl[4]  = '{1, 1, 1, 0, 3, 0, 0, 8'h00, 0};
    tbl[5]  = '{1, 1, 1, 0, 4, 1, 1, 8'h00, 0};
    tbl[6]  = '{1, 1, 0, 0, 2, 0, 1, 8'h00, 0};
    tbl[7]  = '{1, 1, 1, 0, 3, 0, 1, 8'h00, 0};
    tbl[8]  = '{1, 1, 1, 0, 4, 1, 2, 8'h00, 0};
    tbl[9]  = '{1, 1, 1, 0, 1, 0, 2, 8'hB7, 1};
    tbl[10] = '{1, 1, 0, 0, 2, 0, 2, 8'hB7, 0};
    tbl[11] = '{1, 1, 1, 0, 3, 0, 2, 8'hB7, 0};
    tbl[12] = '{1, 0, 1, 0, 3, 0, 2, 8'hB7, 0};
    tbl[13] = '{1, 0, 1, 0, 3, 0, 2, 8'hB7, 0};
    tbl[14] = '{1, 0, 1, 0, 3, 0, 2, 8'hB7, 0};
    tbl[15] = '{1, 1, 1, 0, 4, 1, 3, 8'hB7, 0};
    tbl[16] = '{1, 1, 1, 0, 1, 0, 3, 8'hB7, 0};
    tbl[17] = '{1, 1, 0, 0, 2, 0, 3, 8'hB7, 0};
    tbl[18] = '{1, 1, 1, 0, 3, 0, 3, 8'hB7, 0};
    tbl[19] = '{0, 1, 1, 0, 0, 0, 0, 8'h00, 0};
    tbl[20] = '{1, 1, 1, 0, 1, 0, 0, 8'h00, 0};
    tbl[21] = '{1, 1, 1, 0, 1, 0, 0, 8'h00, 0};

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst_n, tbl[i].hab, tbl[i].ent, tbl[i].clr);
      chk($sformatf("tbl%0d.estado", i),    int'(estado),         tbl[i].st);
      chk($sformatf("tbl%0d.detectado", i), int'(detectado),      tbl[i].det);
      chk($sformatf("tbl%0d.contagem", i),  int'(contagem),       tbl[i].cnt);
      chk($sformatf("tbl%0d.palavra", i),   int'(palavra),        tbl[i].pal);
      chk($sformatf("tbl%0d.valida", i),    int'(palavra_valida), tbl[i].val);
    end

    // Word assembly: 1,0,1,1,0,0,1,0 -> B2, then eight ones -> FF.
    begin
      int bits_b2[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
      int pulses = 0;
      step(0, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
        step(1, 1, bits_b2[i][0], 0);
        pulses += int'(palavra_valida);
      end
      chk("word_b2", int'(palavra), 8'hB2);
      chk("word_b2_pulses", pulses, 1);
      chk("word_b2_pulse_last", int'(palavra_valida), 1);
      step(1, 0, 1, 0);
      chk("word_b2_pulse_drop", int'(palavra_valida), 0);
      for (int i = 0; i < 8; i++) step(1, 1, 1, 0);
      chk("word_ff", int'(palavra), 8'hFF);
    end

    // Counter saturation and clear-on-detection priority.
    step(0, 1, 0, 0);
    for (int r = 0; r < 255; r++) begin
      step(1, 1, 1, 0); step(1, 1, 0, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    end
    chk("sat_255", int'(contagem), 255);
    step(1, 1, 1, 0); step(1, 1, 0, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    chk("sat_hold", int'(contagem), 255);
    chk("sat_det", int'(detectado), 1);
    step(1, 1, 1, 0); step(1, 1, 0, 0); step(1, 1, 1, 0); step(1, 1, 1, 1);
    chk("clr_cnt", int'(contagem), 0);
    chk("clr_det", int'(detectado), 1);

    // Randomized traffic with occasional resets, pauses and clears.
    for (int i = 0; i < 3000; i++) begin
      bit r_n = ($urandom_range(0, 99) != 0);
      bit hb  = ($urandom_range(0, 3) != 0);
      bit en  = $urandom_range(0, 1);
      bit cl  = ($urandom_range(0, 49) == 0);
      step(r_n, hb, en, cl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
